aes_round_sequencer: RTL and testbench

//   Sequences the AES-128 encryption datapath and round-key expansion for one block.

---
 rtl/aes_seq_pkg.sv | 37 +++
 rtl/aes_round_sequencer_if.sv | 22 ++
 rtl/aes_load_edge.sv | 21 ++
 rtl/aes_round_sequencer.sv | 112 +++++++++++
 tb/tb_aes_round_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_seq_pkg.sv
// Shared encodings for the AES-128 round sequencer: state codes, one-hot
// operation strobes and the default round count.
package aes_seq_pkg;

  localparam int NR_DEFAULT = 10;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ARK0  = 3'd1;
  localparam state_t S_SUB   = 3'd2;
  localparam state_t S_SHIFT = 3'd3;
  localparam state_t S_MIX   = 3'd4;
  localparam state_t S_ARK   = 3'd5;
  localparam state_t S_DONE  = 3'd6;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_ARK   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SHIFT = 4'b0100;
  localparam logic [3:0] OP_MIX   = 4'b1000;

  // Datapath operation driven while the FSM sits in a given state.
  function automatic logic [3:0] op_of(state_t s);
    logic [3:0] op;
    op = OP_NONE;
    case (s)
      S_ARK0, S_ARK: op = OP_ARK;
      S_SUB:         op = OP_SUB;
      S_SHIFT:       op = OP_SHIFT;
      S_MIX:         op = OP_MIX;
      default:       op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Sequencer <-> load/datapath bundle. master = sequencer side, slave = datapath/SPI side.
// Handshake: no valid/ready; load is a level whose falling edge starts a block and
// whose rising edge aborts one, all other signals are registered strobes/levels.
interface aes_round_sequencer_if;
  logic       load;
  logic       keyLoad;
  logic       keyUpdate;
  logic [3:0] operation;
  logic [3:0] round;
  logic       busy;
  logic       cipherComplete;

  modport master (
    input  load,
    output keyLoad, keyUpdate, operation, round, busy, cipherComplete
  );

  modport slave (
    output load,
    input  keyLoad, keyUpdate, operation, round, busy, cipherComplete
  );
endinterface

// File: rtl/aes_load_edge.sv
// Registers the SPI load level and turns its edges into start (fall) and
// abort (rise) pulses; both come from one sample so they are exclusive.
module aes_load_edge (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic start,
  output logic abort
);

  logic load_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_q <= 1'b0;
    else        load_q <= load;
  end

  assign start = load_q & ~load;
  assign abort = ~load_q & load;

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: steps ARK0, then SUB/SHIFT/MIX/ARK per round, and
// issues registered one-hot operation and key strobes derived from the next state.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NR        = NR_DEFAULT,
  parameter int SBOX_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_round_sequencer_if.master bus,
  output state_t                state_dbg
);

  localparam int             WW        = (SBOX_WAIT > 0) ? $clog2(SBOX_WAIT + 1) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(SBOX_WAIT);
  localparam logic [3:0]     NR_L      = 4'(NR);

  state_t        state, next_state;
  logic [3:0]    next_round, round_inc;
  logic [WW-1:0] wait_cnt, next_wait;
  logic          start, abort, active;

  aes_load_edge u_load_edge (
    .clk   (clk),
    .reset (reset),
    .load  (bus.load),
    .start (start),
    .abort (abort)
  );

  // Saturating increment: the counter parks at NR instead of wrapping.
  assign round_inc = (bus.round >= NR_L) ? NR_L : bus.round + 4'd1;
  assign active    = (state != S_IDLE) && (state != S_DONE);
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    next_round = bus.round;
    next_wait  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_ARK0;
          next_round = 4'd0;
        end
      end
      S_ARK0: begin
        next_state = S_SUB;
        next_round = round_inc;
        next_wait  = '0;
      end
      S_SUB: begin
        if (wait_cnt == WAIT_LAST) next_state = S_SHIFT;
        else                       next_wait  = wait_cnt + WW'(1);
      end
      S_SHIFT: next_state = (bus.round == NR_L) ? S_ARK : S_MIX;
      S_MIX:   next_state = S_ARK;
      S_ARK: begin
        if (bus.round < NR_L) begin
          next_state = S_SUB;
          next_round = round_inc;
          next_wait  = '0;
        end else begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          next_state = S_ARK0;
          next_round = 4'd0;
        end else if (abort) begin
          next_state = S_IDLE;
          next_round = 4'd0;
        end
      end
      default: begin
        next_state = S_IDLE;
        next_round = 4'd0;
      end
    endcase
    // A rising load mid-block throws the run away.
    if (active && abort) begin
      next_state = S_IDLE;
      next_round = 4'd0;
      next_wait  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      wait_cnt           <= '0;
      bus.round          <= 4'd0;
      bus.operation      <= OP_NONE;
      bus.keyLoad        <= 1'b0;
      bus.keyUpdate      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.cipherComplete <= 1'b0;
    end else begin
      state              <= next_state;
      wait_cnt           <= next_wait;
      bus.round          <= next_round;
      bus.operation      <= op_of(next_state);
      bus.keyLoad        <= (next_state == S_ARK0);
      bus.keyUpdate      <= (next_state == S_SHIFT);
      bus.busy           <= (next_state != S_IDLE) && (next_state != S_DONE);
      bus.cipherComplete <= (next_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: one instance with SBOX_WAIT=1 and one
// with SBOX_WAIT=2, checked against a hand-built per-cycle expectation queue.
module tb_aes_round_sequencer;
  import aes_seq_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t st1, st2;
  int     checks = 0;
  int     errors = 0;

  // Each entry: {keyLoad, keyUpdate, round[3:0], operation[3:0]} for one cycle.
  logic [9:0] exp_q[$];
  logic [9:0] obs1, obs2;

  aes_round_sequencer_if bus1 ();
  aes_round_sequencer_if bus2 ();

  aes_round_sequencer #(.NR(10), .SBOX_WAIT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus1), .state_dbg(st1)
  );

  aes_round_sequencer #(.NR(10), .SBOX_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .state_dbg(st2)
  );

  assign obs1 = {bus1.keyLoad, bus1.keyUpdate, bus1.round, bus1.operation};
  assign obs2 = {bus2.keyLoad, bus2.keyUpdate, bus2.round, bus2.operation};

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected cycle-by-cycle trace from ARK0 to the final ARK for NR=10.
  function automatic void build_exp(int sbox_wait);
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 4'd0, 4'b0001});
    for (int r = 1; r <= 10; r++) begin
      for (int w = 0; w <= sbox_wait; w++) exp_q.push_back({1'b0, 1'b0, 4'(r), 4'b0010});
      exp_q.push_back({1'b0, 1'b1, 4'(r), 4'b0100});
      if (r < 10) exp_q.push_back({1'b0, 1'b0, 4'(r), 4'b1000});
      exp_q.push_back({1'b0, 1'b0, 4'(r), 4'b0001});
    end
  endfunction

  // Driver: load 1 -> 0 on dut; returns at the negedge where ARK0 should be visible.
  task automatic start1();
    @(negedge clk) bus1.load = 1'b1;
    @(negedge clk) bus1.load = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus1.load = 1'b0;
    bus2.load = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs1 !== 10'd0 || bus1.busy !== 1'b0 || bus1.cipherComplete !== 1'b0 || st1 !== S_IDLE) begin
      errors++;
      $display("FAIL reset_dut1: got obs=%h busy=%b cc=%b st=%0d expected 000/0/0/0", obs1, bus1.busy, bus1.cipherComplete, st1);
    end
    checks++;
    if (obs2 !== 10'd0 || bus2.busy !== 1'b0 || bus2.cipherComplete !== 1'b0 || st2 !== S_IDLE) begin
      errors++;
      $display("FAIL reset_dut2: got obs=%h busy=%b cc=%b st=%0d expected 000/0/0/0", obs2, bus2.busy, bus2.cipherComplete, st2);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs1 !== 10'd0 || bus1.busy !== 1'b0 || st1 !== S_IDLE) begin
      errors++;
      $display("FAIL idle_after_reset: got obs=%h busy=%b st=%0d expected idle", obs1, bus1.busy, st1);
    end
  endtask

  task automatic test_full_run();
    int     n_ku;
    logic   saw_shift_ark;
    state_t prev;
    build_exp(1);
    n_ku = 0;
    saw_shift_ark = 1'b0;
    prev = S_IDLE;
    start1();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs1 !== exp_q[i] || bus1.busy !== 1'b1 || bus1.cipherComplete !== 1'b0) begin
        errors++;
        $display("FAIL full_run[%0d]: got %h busy=%b cc=%b expected %h busy=1 cc=0", i, obs1, bus1.busy, bus1.cipherComplete, exp_q[i]);
      end
      checks++;
      if (bus1.round == 4'd10 && bus1.operation == 4'b1000) begin
        errors++;
        $display("FAIL no_mix_round10[%0d]: got op=%b expected no MixColumns", i, bus1.operation);
      end
      if (bus1.keyUpdate === 1'b1) n_ku++;
      if (prev == S_SHIFT && st1 == S_ARK && bus1.round == 4'd10) saw_shift_ark = 1'b1;
      prev = st1;
    end
    @(negedge clk);
    checks++;
    if (bus1.cipherComplete !== 1'b1 || bus1.round !== 4'd10 || bus1.operation !== 4'b0000 || bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle51: got cc=%b round=%0d op=%b busy=%b expected 1/10/0000/0", bus1.cipherComplete, bus1.round, bus1.operation, bus1.busy);
    end
    checks++;
    if (n_ku != 10) begin
      errors++;
      $display("FAIL keyupdate_count: got %0d expected 10", n_ku);
    end
    checks++;
    if (saw_shift_ark !== 1'b1) begin
      errors++;
      $display("FAIL shift_to_ark_round10: got %b expected 1", saw_shift_ark);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus1.cipherComplete !== 1'b1 || st1 !== S_DONE || bus1.round !== 4'd10) begin
      errors++;
      $display("FAIL done_hold: got cc=%b st=%0d round=%0d expected 1/DONE/10", bus1.cipherComplete, st1, bus1.round);
    end
  endtask

  task automatic test_abort();
    build_exp(1);
    @(negedge clk) bus1.load = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.cipherComplete !== 1'b0 || st1 !== S_IDLE) begin
      errors++;
      $display("FAIL done_to_idle: got cc=%b st=%0d expected 0/IDLE", bus1.cipherComplete, st1);
    end
    bus1.load = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1 !== exp_q[0]) begin
      errors++;
      $display("FAIL restart_ark0: got %h expected %h", obs1, exp_q[0]);
    end
    repeat (20) @(negedge clk);
    bus1.load = 1'b1;
    @(negedge clk);
    checks++;
    if (obs1 !== 10'd0 || bus1.busy !== 1'b0 || bus1.cipherComplete !== 1'b0 || st1 !== S_IDLE) begin
      errors++;
      $display("FAIL abort: got obs=%h busy=%b cc=%b st=%0d expected idle", obs1, bus1.busy, bus1.cipherComplete, st1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs1 !== 10'd0 || bus1.busy !== 1'b0 || bus1.cipherComplete !== 1'b0) begin
        errors++;
        $display("FAIL load_held_high[%0d]: got obs=%h busy=%b cc=%b expected quiet", i, obs1, bus1.busy, bus1.cipherComplete);
      end
    end
    bus1.load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs1 !== exp_q[i] || bus1.busy !== 1'b1) begin
        errors++;
        $display("FAIL rerun[%0d]: got %h busy=%b expected %h busy=1", i, obs1, bus1.busy, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus1.cipherComplete !== 1'b1 || bus1.round !== 4'd10) begin
      errors++;
      $display("FAIL rerun_done: got cc=%b round=%0d expected 1/10", bus1.cipherComplete, bus1.round);
    end
  endtask

  task automatic test_reset_mid_run();
    logic found;
    found = 1'b0;
    start1();
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus1.round == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL reach_round5: got round=%0d expected 5 within 60 cycles", bus1.round);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== 10'd0 || bus1.busy !== 1'b0 || bus1.cipherComplete !== 1'b0 || st1 !== S_IDLE) begin
      errors++;
      $display("FAIL async_reset: got obs=%h busy=%b cc=%b st=%0d expected all zero", obs1, bus1.busy, bus1.cipherComplete, st1);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs1 !== 10'd0 || bus1.busy !== 1'b0 || st1 !== S_IDLE) begin
        errors++;
        $display("FAIL quiet_after_reset[%0d]: got obs=%h busy=%b st=%0d expected idle", i, obs1, bus1.busy, st1);
      end
    end
  endtask

  task automatic test_sbox_wait2();
    build_exp(2);
    @(negedge clk) bus2.load = 1'b1;
    @(negedge clk) bus2.load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs2 !== exp_q[i] || bus2.busy !== 1'b1) begin
        errors++;
        $display("FAIL sbox2[%0d]: got %h busy=%b expected %h busy=1", i, obs2, bus2.busy, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus2.cipherComplete !== 1'b1 || bus2.round !== 4'd10) begin
      errors++;
      $display("FAIL sbox2_done_cycle61: got cc=%b round=%0d expected 1/10", bus2.cipherComplete, bus2.round);
    end
    @(negedge clk) bus2.load = 1'b1;
    @(negedge clk);
    checks++;
    if (bus2.cipherComplete !== 1'b0 || st2 !== S_IDLE) begin
      errors++;
      $display("FAIL sbox2_cc_drop: got cc=%b st=%0d expected 0/IDLE", bus2.cipherComplete, st2);
    end
    bus2.load = 1'b0;
    @(negedge clk);
    checks++;
    if (obs2 !== exp_q[0] || bus2.busy !== 1'b1) begin
      errors++;
      $display("FAIL sbox2_restart: got %h busy=%b expected %h busy=1", obs2, bus2.busy, exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_abort();
    test_reset_mid_run();
    test_sbox_wait2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
